// File: rtl/fp32_product_accumulator.sv
// Sequential FP32 accumulator: sums LEN products from the approximate multiplier
// through an IDLE/ALIGN/ADD/NORM/DONE pipeline-in-time, truncating (no rounding).
module fp32_product_accumulator #(
    parameter int LEN   = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_exc,
    input  logic        in_ovf,
    input  logic        in_unf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        exc_o,
    output logic        ovf_o,
    output logic        unf_o
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]      acc;
    logic [31:0]      op;
    logic             op_inf;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             exc_r, ovf_r, unf_r;

    logic [23:0] a_mant, b_mant;
    logic [7:0]  a_exp;
    logic        a_sign, b_sign;
    logic [24:0] raw_sum;

    // ALIGN: order operands by magnitude, then truncate-shift the smaller one
    logic [7:0]  acc_exp, op_exp, big_exp, small_exp, exp_diff;
    logic [23:0] acc_mant, op_mant, big_mant, small_mant, shifted_mant;
    logic        swap, big_sign, small_sign;

    always_comb begin
        acc_exp    = acc[30:23];
        op_exp     = op[30:23];
        acc_mant   = (acc_exp == '0) ? '0 : {1'b1, acc[22:0]};
        op_mant    = (op_exp == '0) ? '0 : {1'b1, op[22:0]};
        swap       = {op_exp, op_mant} > {acc_exp, acc_mant};
        big_exp    = swap ? op_exp : acc_exp;
        big_mant   = swap ? op_mant : acc_mant;
        big_sign   = swap ? op[31] : acc[31];
        small_exp  = swap ? acc_exp : op_exp;
        small_mant = swap ? acc_mant : op_mant;
        small_sign = swap ? acc[31] : op[31];
        exp_diff   = big_exp - small_exp;
        shifted_mant = (exp_diff >= 8'd25) ? '0 : (small_mant >> exp_diff);
    end

    logic [4:0]        lzc;
    logic [22:0]       norm_frac;
    logic signed [9:0] norm_exp;
    logic [31:0]       norm_res;
    logic              norm_ovf, norm_unf;

    always_comb begin
        lzc = '0;
        for (int unsigned i = 0; i < 24; i++) begin
            if (raw_sum[i]) lzc = 5'(23 - i);
        end
        norm_ovf  = 1'b0;
        norm_unf  = 1'b0;
        norm_res  = '0;
        norm_frac = '0;
        norm_exp  = '0;
        if (raw_sum[24]) begin
            norm_exp  = $signed({2'b00, a_exp}) + 10'sd1;
            norm_frac = raw_sum[23:1];
        end else begin
            norm_exp  = $signed({2'b00, a_exp}) - $signed({5'b00000, lzc});
            norm_frac = raw_sum[22:0] << lzc;
        end
        if (raw_sum != '0) begin
            if (norm_exp >= 10'sd255) begin
                norm_res = {a_sign, 8'hFF, 23'd0};
                norm_ovf = 1'b1;
            end else if (norm_exp <= 10'sd0) begin
                norm_unf = 1'b1;
            end else begin
                norm_res = {a_sign, norm_exp[7:0], norm_frac};
            end
        end
    end

    assign count_inc = count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) state_nxt = ALIGN;
            end
            ALIGN: state_nxt = ADD;
            ADD:   state_nxt = NORM;
            NORM:  state_nxt = (count_inc == CNT_W'(LEN)) ? DONE : IDLE;
            DONE: begin
                out_valid = ~rst;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            exc_r <= 1'b0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op     <= in_data;
                    op_inf <= in_exc | in_ovf | (in_data[30:23] == 8'hFF);
                    exc_r  <= exc_r | in_exc | (in_data[30:23] == 8'hFF);
                    ovf_r  <= ovf_r | in_ovf;
                    unf_r  <= unf_r | in_unf;
                end
                ALIGN: begin
                    a_mant <= big_mant;
                    b_mant <= shifted_mant;
                    a_exp  <= big_exp;
                    a_sign <= big_sign;
                    b_sign <= small_sign;
                end
                ADD: begin
                    raw_sum <= (a_sign == b_sign) ? ({1'b0, a_mant} + {1'b0, b_mant})
                                                  : ({1'b0, a_mant} - {1'b0, b_mant});
                end
                NORM: begin
                    // An Inf accumulator absorbs everything until the batch ends
                    if (acc[30:23] != 8'hFF) begin
                        if (op_inf) begin
                            acc <= {op[31], 8'hFF, 23'd0};
                        end else begin
                            acc   <= norm_res;
                            ovf_r <= ovf_r | norm_ovf;
                            unf_r <= unf_r | norm_unf;
                        end
                    end
                    count <= count_inc;
                end
                DONE: if (out_ready) begin
                    acc   <= '0;
                    count <= '0;
                    exc_r <= 1'b0;
                    ovf_r <= 1'b0;
                    unf_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sum   = acc;
    assign exc_o = exc_r;
    assign ovf_o = ovf_r;
    assign unf_o = unf_r;

endmodule

// File: tb/tb_fp32_product_accumulator.sv
// Bench for fp32_product_accumulator (LEN=4): directed scenarios plus random
// batches checked against an integer-arithmetic model of truncating FP32 addition.
module tb_fp32_product_accumulator;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_exc = 1'b0, in_ovf = 1'b0, in_unf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        exc_o, ovf_o, unf_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp32_product_accumulator #(.LEN(LEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_exc(in_exc), .in_ovf(in_ovf), .in_unf(in_unf),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .exc_o(exc_o), .ovf_o(ovf_o), .unf_o(unf_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // value = mant * 2^(exp-150); B is truncated to A's ulp before the add
    function automatic void model_step(input logic [31:0] acc, input logic [31:0] op,
                                       input logic op_flag_inf, output logic [31:0] res,
                                       output logic ov, output logic un);
        int ea, eb, d, len, en, ti;
        longint ma, mb, bt, s, m, tl;
        logic sa, sb, tb;
        ov = 1'b0;
        un = 1'b0;
        res = acc;
        if (acc[30:23] == 8'hFF) begin
            res = acc;
        end else if (op_flag_inf || op[30:23] == 8'hFF) begin
            res = {op[31], 8'hFF, 23'd0};
        end else begin
            ea = int'(acc[30:23]);
            eb = int'(op[30:23]);
            ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(acc[22:0]);
            mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(op[22:0]);
            sa = acc[31];
            sb = op[31];
            if (eb > ea || (eb == ea && mb > ma)) begin
                ti = ea; ea = eb; eb = ti;
                tl = ma; ma = mb; mb = tl;
                tb = sa; sa = sb; sb = tb;
            end
            d  = ea - eb;
            bt = (d >= 25) ? 0 : (mb >> d);
            s  = (sa == sb) ? ma + bt : ma - bt;
            if (s == 0) begin
                res = '0;
            end else begin
                len = 0;
                while ((s >> len) != 0) len++;
                en = ea + len - 24;
                m  = (len == 25) ? (s >> 1) : (s << (24 - len));
                if (en >= 255) begin
                    res = {sa, 8'hFF, 23'd0};
                    ov  = 1'b1;
                end else if (en <= 0) begin
                    res = '0;
                    un  = 1'b1;
                end else begin
                    res = {sa, 8'(en), m[22:0]};
                end
            end
        end
    endfunction

    // f[i] = {exc, ovf, unf}; fl = expected {exc_o, ovf_o, unf_o}
    function automatic void model_batch(input logic [31:0] d[LEN], input logic [2:0] f[LEN],
                                        output logic [31:0] res, output logic [2:0] fl);
        logic [31:0] acc, nxt;
        logic ov, un;
        acc = '0;
        fl  = '0;
        for (int i = 0; i < LEN; i++) begin
            fl[2] = fl[2] | f[i][2] | (d[i][30:23] == 8'hFF);
            fl[1] = fl[1] | f[i][1];
            fl[0] = fl[0] | f[i][0];
            model_step(acc, d[i], f[i][2] | f[i][1], nxt, ov, un);
            acc   = nxt;
            fl[1] = fl[1] | ov;
            fl[0] = fl[0] | un;
        end
        res = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [31:0] d, input logic [2:0] f, output bit ok);
        int guard;
        in_data = d;
        {in_exc, in_ovf, in_unf} = f;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        ok = in_ready;
        tick();
    endtask

    task automatic wait_out(output bit ok);
        int guard;
        guard = 0;
        while (!out_valid && guard < 40) begin
            tick();
            guard++;
        end
        ok = out_valid;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_batch(input logic [31:0] d[LEN], input logic [2:0] f[LEN],
                             output bit ok, output logic [31:0] s, output logic [2:0] fl);
        bit k;
        ok = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            send_op(d[i], f[i], k);
            ok = ok & k;
        end
        in_valid = 1'b0;
        {in_exc, in_ovf, in_unf} = 3'b000;
        wait_out(k);
        ok = ok & k;
        s  = sum;
        fl = {exc_o, ovf_o, unf_o};
        take_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_assert++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_assert++;
        if (sum !== 32'h0 || {exc_o, ovf_o, unf_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_sum_flags: got %h/%b expected 00000000/000", sum, {exc_o, ovf_o, unf_o});
        end
        rst = 1'b0;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic_sum();
        int t_first, accepts, last_c;
        bit rdy_ok, rdy_before;
        t_first = -1; accepts = 0; last_c = -1; rdy_ok = 1'b1;
        in_data = 32'h3F800000;
        {in_exc, in_ovf, in_unf} = 3'b000;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rdy_before = in_ready;
            tick();
            if (rdy_before) begin
                if (t_first < 0) t_first = c;
                if ((c - t_first) % 4 != 0) rdy_ok = 1'b0;
                accepts++;
            end
            if (out_valid) begin
                last_c = c;
                break;
            end
        end
        in_valid = 1'b0;
        n_assert++;
        if (last_c - t_first + 1 != 16 || last_c < 0) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 16", last_c - t_first + 1);
        end
        n_assert++;
        if (accepts != 4 || !rdy_ok) begin
            n_fail++; $display("FAIL basic_ready_pattern: got %0d accepts (spacing ok=%b) expected 4 every 4th cycle", accepts, rdy_ok);
        end
        n_assert++;
        if (sum !== 32'h40800000) begin
            n_fail++; $display("FAIL basic_sum: got %h expected 40800000", sum);
        end
        n_assert++;
        if ({exc_o, ovf_o, unf_o} !== 3'b000) begin
            n_fail++; $display("FAIL basic_flags: got %b expected 000", {exc_o, ovf_o, unf_o});
        end
        take_out();
    endtask

    task automatic test_cancel_trunc();
        logic [31:0] d[LEN];
        logic [2:0]  f[LEN];
        logic [31:0] s;
        logic [2:0]  fl;
        bit ok;
        f = '{3'b000, 3'b000, 3'b000, 3'b000};
        d = '{32'h3FC00000, 32'hBFC00000, 32'h0, 32'h0};
        run_batch(d, f, ok, s, fl);
        n_assert++;
        if (!ok || s !== 32'h00000000) begin
            n_fail++; $display("FAIL cancel_sum: got %h (ok=%b) expected 00000000", s, ok);
        end
        d = '{32'h3F800000, 32'h33800000, 32'h0, 32'h0};
        run_batch(d, f, ok, s, fl);
        n_assert++;
        if (!ok || s !== 32'h3F800000) begin
            n_fail++; $display("FAIL trunc_sum: got %h (ok=%b) expected 3F800000", s, ok);
        end
        n_assert++;
        if (fl !== 3'b000) begin
            n_fail++; $display("FAIL trunc_flags: got %b expected 000", fl);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d[LEN];
        logic [2:0]  f[LEN];
        logic [31:0] s;
        logic [2:0]  fl;
        bit ok;
        f = '{3'b000, 3'b000, 3'b000, 3'b000};
        d = '{32'h7F000000, 32'h7F000000, 32'h3F800000, 32'h0};
        run_batch(d, f, ok, s, fl);
        n_assert++;
        if (!ok || s !== 32'h7F800000) begin
            n_fail++; $display("FAIL ovf_sum: got %h (ok=%b) expected 7F800000", s, ok);
        end
        n_assert++;
        if (fl !== 3'b010) begin
            n_fail++; $display("FAIL ovf_flags: got %b expected 010", fl);
        end
    endtask

    task automatic test_mult_flags();
        logic [31:0] d[LEN];
        logic [2:0]  f[LEN];
        logic [31:0] s;
        logic [2:0]  fl;
        bit ok;
        f = '{3'b000, 3'b100, 3'b000, 3'b000};
        d = '{32'h3F800000, 32'hFF800000, 32'h3F800000, 32'h0};
        run_batch(d, f, ok, s, fl);
        n_assert++;
        if (!ok || s !== 32'hFF800000) begin
            n_fail++; $display("FAIL exc_sum: got %h (ok=%b) expected FF800000", s, ok);
        end
        n_assert++;
        if (fl !== 3'b100) begin
            n_fail++; $display("FAIL exc_flags: got %b expected 100", fl);
        end
        f = '{3'b001, 3'b000, 3'b000, 3'b000};
        d = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        run_batch(d, f, ok, s, fl);
        n_assert++;
        if (!ok || s !== 32'h40400000) begin
            n_fail++; $display("FAIL unf_sum: got %h (ok=%b) expected 40400000", s, ok);
        end
        n_assert++;
        if (fl !== 3'b001) begin
            n_fail++; $display("FAIL unf_flags: got %b expected 001", fl);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s0;
        logic [2:0]  f0;
        bit ok, k;
        ok = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            send_op(32'h3F800000, 3'b000, k);
            ok = ok & k;
        end
        in_valid = 1'b0;
        wait_out(k);
        ok = ok & k;
        s0 = sum;
        f0 = {exc_o, ovf_o, unf_o};
        n_assert++;
        if (!ok || s0 !== 32'h40800000 || f0 !== 3'b000) begin
            n_fail++; $display("FAIL bp_first_sum: got %h/%b (ok=%b) expected 40800000/000", s0, f0, ok);
        end
        in_data = 32'h40000000;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_assert++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== s0 || {exc_o, ovf_o, unf_o} !== f0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b sum=%h flags=%b expected 1/0/%h/%b",
                         c, out_valid, in_ready, sum, {exc_o, ovf_o, unf_o}, s0, f0);
            end
        end
        take_out();
        n_assert++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        wait_out(k);
        in_valid = 1'b0;
        n_assert++;
        if (!k || sum !== 32'h41000000) begin
            n_fail++; $display("FAIL bp_second_sum: got %h (ok=%b) expected 41000000", sum, k);
        end
        take_out();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d[LEN];
        logic [2:0]  f[LEN];
        logic [31:0] s;
        logic [2:0]  fl;
        bit ok, k;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_op(32'h3F800000, 3'b000, k);
            ok = ok & k;
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_assert++;
        if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'h0) begin
            n_fail++; $display("FAIL midrst_state: got valid=%b ready=%b sum=%h (ok=%b) expected 0/1/00000000", out_valid, in_ready, sum, ok);
        end
        f = '{3'b000, 3'b000, 3'b000, 3'b000};
        d = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        run_batch(d, f, ok, s, fl);
        n_assert++;
        if (!ok || s !== 32'h40800000 || fl !== 3'b000) begin
            n_fail++; $display("FAIL midrst_fresh: got %h/%b (ok=%b) expected 40800000/000", s, fl, ok);
        end
    endtask

    function automatic logic [31:0] rand_op(input int mode);
        logic [7:0] e;
        int r;
        r = $urandom_range(0, 19);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else begin
            case (mode)
                0:       e = 8'($urandom_range(118, 136));
                1:       e = 8'($urandom_range(250, 254));
                default: e = 8'($urandom_range(1, 6));
            endcase
        end
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] d[LEN];
        logic [2:0]  f[LEN];
        logic [31:0] s, exp_s;
        logic [2:0]  fl, exp_fl;
        bit ok;
        int mode;
        for (int b = 0; b < 40; b++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < LEN; i++) begin
                d[i] = rand_op(mode);
                f[i] = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            end
            model_batch(d, f, exp_s, exp_fl);
            run_batch(d, f, ok, s, fl);
            n_assert++;
            if (!ok || s !== exp_s) begin
                n_fail++;
                $display("FAIL rand_sum batch %0d: got %h (ok=%b) expected %h ops %h %h %h %h",
                         b, s, ok, exp_s, d[0], d[1], d[2], d[3]);
            end
            n_assert++;
            if (fl !== exp_fl) begin
                n_fail++; $display("FAIL rand_flags batch %0d: got %b expected %b", b, fl, exp_fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_cancel_trunc();
        test_overflow();
        test_mult_flags();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_product_accumulator.md
# fp32_product_accumulator

Sequential FP32 accumulator directly downstream of the approximate FP32 mantissa-approx multiplier (`Mult_approx`). It consumes the multiplier's `result` word and its `Exception`/`Overflow`/`Underflow` flags over a valid/ready handshake. It sums `LEN` consecutive products with a 4-cycle multi-state adder and presents the FP32 sum with sticky flags over a valid/ready output. This forms the reduction half of the dot-product path.

## Interface
- `LEN`, 16: products per accumulation; legal range 1..65535.
- `CNT_W`, 16: width of the product counter; must satisfy 2^CNT_W > LEN.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: product word and flags are valid.
- `in_ready` output 1: block accepts a product; equals (state==IDLE) & ~rst.
- `in_data` input 32: multiplier `result` (sign, exp[7:0], mant[22:0]).
- `in_exc` input 1: multiplier `Exception`.
- `in_ovf` input 1: multiplier `Overflow`.
- `in_unf` input 1: multiplier `Underflow`.
- `out_valid` output 1: `sum` and flags are valid; held until accepted.
- `out_ready` input 1: consumer accepts the sum.
- `sum` output 32: FP32 accumulated value.
- `exc_o` output 1: sticky; at least one input in this batch had in_exc, or had exp==8'hFF.
- `ovf_o` output 1: sticky; input in_ovf, or the accumulator exponent overflowed.
- `unf_o` output 1: sticky; input in_unf, or the accumulator result was flushed to zero.

## Operation
- **FSM states:** IDLE, ALIGN, ADD, NORM, DONE.
- **IDLE:** on in_valid&in_ready, latch the operand and OR the input flags into the sticky flags, then go to ALIGN.
- **Operand decode:**
  - exp==0 is treated as zero; denormals are flushed.
  - exp==8'hFF, in_exc or in_ovf makes the operand ±Inf with the sign of in_data[31].
- **ALIGN:**
  - Build 24-bit mantissas with the hidden bit for both the operand and the accumulator.
  - Swap so the larger magnitude is A.
  - Right-shift B by the exponent difference. A difference ≥25 makes B zero. Shifted-out bits are truncated; there is no rounding.
- **ADD:**
  - Equal signs: 25-bit sum.
  - Differing signs: A−B, with the sign of A.
- **NORM:**
  - Carry out: shift right by 1, exp+1.
  - Otherwise: left-shift by the leading-zero count and subtract that count from exp.
  - Exact zero result: +0 (0x00000000).
  - Normalised exp ≤0: +0, set unf.
  - exp ≥255: ±Inf ({sign, 8'hFF, 23'd0}), set ovf.
  - Write the accumulator, then increment the counter.
  - If counter==LEN go to DONE, else go to IDLE.
- **Inf handling:** once the accumulator is Inf it stays Inf (first sign wins) for the rest of the batch, and later operands are ignored. An Inf operand into a finite accumulator sets the accumulator to that Inf.
- **DONE:**
  - out_valid=1, with sum and flags held stable.
  - On out_ready, clear the accumulator to +0, the counter to 0 and all sticky flags, then go to IDLE.
- **Reset (any state, including mid-batch):**
  - state=IDLE, accumulator=+0, counter=0.
  - Outputs: out_valid=0, sum=0, exc_o=ovf_o=unf_o=0, in_ready=0 while rst is high.
  - No partial batch survives reset.

## Timing
- Product accepted at edge T; ALIGN at T+1, ADD at T+2, NORM at T+3.
- Next state (IDLE or DONE) is in effect from T+4:
  - in_ready rises at T+4 (mid-batch).
  - out_valid rises at T+4 after the LEN-th product.
- Throughput: one product per 4 cycles. Batch latency from first accept to out_valid is 4·LEN cycles with in_valid held high.
- in_ready is low in ALIGN, ADD, NORM and DONE. in_valid during those states is ignored and the upstream word must be held.
- DONE with out_ready=1 on the first out_valid cycle: handshake completes and in_ready=1 on the following cycle. There is no overlap between output and the next batch.
- out_ready while out_valid=0 has no effect.
- Input flags are sampled only on the accepting edge.

## Test plan
- **Basic sum:** LEN=4, four × 0x3F800000 (1.0), in_valid held high → out_valid at cycle 16 after the first accept. sum=0x40800000, all flags 0, in_ready high every 4th cycle.
- **Cancellation and truncation:**
  - LEN=2, 0x3FC00000 then 0xBFC00000 → sum=0x00000000.
  - LEN=2, 0x3F800000 then 0x33800000 (2^-24) → sum=0x3F800000 (truncation).
- **Exponent overflow:** LEN=2, 0x7F000000 twice → sum=0x7F800000, ovf_o=1, exc_o=0.
- **Multiplier flags:**
  - LEN=3: 0x3F800000, then 0xFF800000 with in_exc=1, then 0x3F800000 → sum=0xFF800000, exc_o=1.
  - Next batch: in_unf=1 on a 0x00000000 word → unf_o=1, and exc_o cleared.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE → sum and flags are stable, out_valid=1, in_ready=0. Offered inputs are not consumed; the first accept occurs the cycle after out_ready=1.
- **Reset mid-batch:** rst pulse during ADD of product 3 of LEN=4 → next cycle out_valid=0, in_ready=1. A fresh batch of four × 1.0 yields 0x40800000.
